td4_prog_loader: RTL and testbench

Writable program store for the TD4 CPU, replacing the fixed instruction ROM. It accepts a 16-byte program plus a checksum byte over a valid/ready byte stream and writes it into a 16×8 register array. It serves instruction fetch through the same 4-bit address / 8-bit data read port the CPU already uses. While loading, or after a failed load, it holds the CPU in reset.

---
 rtl/td4_pkg.sv | 29 ++
 rtl/td4_prog_ram.sv | 29 ++
 rtl/td4_prog_loader.sv | 102 ++++++++++
 tb/tb_td4_prog_loader.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/td4_pkg.sv
// rtl/td4_pkg.sv - shared TD4 widths, loader state encoding and opcode constants
package td4_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2,
    FAIL  = 2'd3
  } loader_state_t;

  // Upper nibble of a TD4 instruction; the lower nibble is the immediate.
  localparam logic [3:0] ADD_A  = 4'b0000;
  localparam logic [3:0] MOV_AB = 4'b0001;
  localparam logic [3:0] IN_A   = 4'b0010;
  localparam logic [3:0] MOV_A  = 4'b0011;
  localparam logic [3:0] MOV_BA = 4'b0100;
  localparam logic [3:0] ADD_B  = 4'b0101;
  localparam logic [3:0] IN_B   = 4'b0110;
  localparam logic [3:0] MOV_B  = 4'b0111;
  localparam logic [3:0] OUT_B  = 4'b1001;
  localparam logic [3:0] OUT_IM = 4'b1011;
  localparam logic [3:0] JNC    = 4'b1110;
  localparam logic [3:0] JMP    = 4'b1111;

endpackage

// File: rtl/td4_prog_ram.sv
// rtl/td4_prog_ram.sv - 16x8 program register array, one sync write, one comb read
module td4_prog_ram #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Cleared words decode as ADD A,0 so a freshly reset CPU just spins.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/td4_prog_loader.sv
// rtl/td4_prog_loader.sv - streams a 16-byte program plus checksum into the TD4 store
module td4_prog_loader
  import td4_pkg::*;
#(
  parameter int DEPTH  = td4_pkg::DEPTH,
  parameter int DATA_W = td4_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              load_start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_error
);

  loader_state_t     state, state_next;
  logic [ADDR_W-1:0] wr_addr, wr_addr_next;
  logic [DATA_W-1:0] sum, sum_next;
  logic              done_next, error_next;
  logic              we;
  logic              accept;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state      <= IDLE;
      wr_addr    <= '0;
      sum        <= '0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      state      <= state_next;
      wr_addr    <= wr_addr_next;
      sum        <= sum_next;
      load_done  <= done_next;
      load_error <= error_next;
    end
  end

  assign in_ready = (state == LOAD) || (state == CHECK);
  assign cpu_hold = (state != IDLE);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_next   = state;
    wr_addr_next = wr_addr;
    sum_next     = sum;
    done_next    = load_done;
    error_next   = load_error;
    we           = 1'b0;
    // A restart wins over any byte arriving in the same cycle.
    if (load_start) begin
      state_next   = LOAD;
      wr_addr_next = '0;
      sum_next     = '0;
      done_next    = 1'b0;
      error_next   = 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (accept) begin
            we           = 1'b1;
            sum_next     = sum + in_data;
            wr_addr_next = wr_addr + 1'b1;
            if (wr_addr == ADDR_W'(DEPTH - 1)) state_next = CHECK;
          end
        end
        CHECK: begin
          if (accept) begin
            if (in_data == sum) begin
              state_next = IDLE;
              done_next  = 1'b1;
            end else begin
              state_next = FAIL;
              error_next = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  td4_prog_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .n_reset (n_reset),
    .we      (we),
    .waddr   (wr_addr),
    .wdata   (in_data),
    .raddr   (address),
    .rdata   (data)
  );

endmodule

// File: tb/tb_td4_prog_loader.sv
// tb/tb_td4_prog_loader.sv - directed self-checking bench for td4_prog_loader
module tb_td4_prog_loader;
  import td4_pkg::*;

  logic       clk;
  logic       n_reset;
  logic       load_start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [3:0] address;
  logic [7:0] data;
  logic       cpu_hold;
  logic       load_done;
  logic       load_error;

  int checks;
  int errors;
  logic [7:0] prog [17];
  logic [7:0] exp_mem [16];
  int rdy_cycles;
  int tot_cycles;

  td4_prog_loader dut (
    .clk        (clk),
    .n_reset    (n_reset),
    .load_start (load_start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .address    (address),
    .data       (data),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_error (load_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_mem(input string tag);
    for (int k = 0; k < 16; k++) begin
      address = 4'(k);
      #1;
      chk($sformatf("%s_mem%0d", tag, k), {24'h0, data}, {24'h0, exp_mem[k]});
    end
  endtask

  // Streams prog[0..16]; optionally pulses load_start first and inserts idle gaps.
  task automatic stream(input bit do_start, input bit gaps, output int rdy, output int cyc);
    int  idx;
    bit  v;
    bit  acc;
    if (do_start) begin
      @(negedge clk) load_start = 1'b1;
      @(negedge clk) load_start = 1'b0;
    end
    idx = 0;
    cyc = 0;
    rdy = 0;
    while (idx < 17 && cyc < 300) begin
      if (!gaps) v = 1'b1;
      else v = !(cyc >= 6 && cyc < 16) && ($urandom_range(0, 3) != 0);
      in_valid = v;
      in_data  = v ? prog[idx] : 8'h5A;
      #1;
      if (in_ready) rdy++;
      acc = v && in_ready;
      @(negedge clk);
      cyc++;
      if (acc) idx++;
    end
    in_valid = 1'b0;
    chk("stream_complete", idx, 17);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    n_reset    = 1'b1;
    load_start = 1'b0;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    address    = 4'h0;

    // Reset state
    #1 n_reset = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 16; k++) exp_mem[k] = 8'h00;
    check_mem("reset");
    chk("reset_cpu_hold", cpu_hold, 0);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_load_done", load_done, 0);
    chk("reset_load_error", load_error, 0);
    @(negedge clk) n_reset = 1'b1;
    @(negedge clk);

    // Good load 0x00..0x0F, checksum 0x78
    for (int k = 0; k < 16; k++) prog[k] = 8'(k);
    prog[16] = 8'h78;
    stream(1'b1, 1'b0, rdy_cycles, tot_cycles);
    chk("good_ready_cycles", rdy_cycles, 17);
    chk("good_latency", tot_cycles, 17);
    chk("good_load_done", load_done, 1);
    chk("good_cpu_hold", cpu_hold, 0);
    chk("good_in_ready", in_ready, 0);
    chk("good_load_error", load_error, 0);
    for (int k = 0; k < 16; k++) exp_mem[k] = 8'(k);
    check_mem("good");

    // Bad checksum, then recovery
    prog[16] = 8'h77;
    stream(1'b1, 1'b0, rdy_cycles, tot_cycles);
    chk("bad_load_error", load_error, 1);
    chk("bad_load_done", load_done, 0);
    chk("bad_cpu_hold", cpu_hold, 1);
    chk("bad_in_ready", in_ready, 0);
    repeat (3) @(negedge clk);
    chk("bad_hold_sticky", cpu_hold, 1);
    check_mem("bad");
    prog[16] = 8'h78;
    stream(1'b1, 1'b0, rdy_cycles, tot_cycles);
    chk("recover_load_error", load_error, 0);
    chk("recover_load_done", load_done, 1);
    chk("recover_cpu_hold", cpu_hold, 0);

    // Backpressure with random gaps and a 10-cycle hole
    for (int k = 0; k < 16; k++) prog[k] = 8'h30 + 8'(k);
    prog[16] = 8'h78;  // 16*0x30 = 0x300, carry discarded
    stream(1'b1, 1'b1, rdy_cycles, tot_cycles);
    chk("bp_load_done", load_done, 1);
    chk("bp_load_error", load_error, 0);
    for (int k = 0; k < 16; k++) exp_mem[k] = 8'h30 + 8'(k);
    check_mem("bp");

    // Restart after 5 bytes together with a valid 0xAA
    @(negedge clk) load_start = 1'b1;
    @(negedge clk) load_start = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 8'h10 + 8'(i);
      @(negedge clk);
    end
    load_start = 1'b1;
    in_data    = 8'hAA;
    @(negedge clk);
    load_start = 1'b0;
    in_valid   = 1'b0;
    chk("restart_in_ready", in_ready, 1);
    chk("restart_cpu_hold", cpu_hold, 1);
    address = 4'd5;
    #1 chk("restart_aa_not_written", data, 8'h35);
    address = 4'd0;
    #1 chk("restart_kept_word0", data, 8'h10);
    address = 4'd4;
    #1 chk("restart_kept_word4", data, 8'h14);
    for (int k = 0; k < 16; k++) prog[k] = 8'h01;
    prog[16] = 8'h10;
    stream(1'b0, 1'b0, rdy_cycles, tot_cycles);
    chk("restart_load_done", load_done, 1);
    chk("restart_load_error", load_error, 0);
    for (int k = 0; k < 16; k++) exp_mem[k] = 8'h01;
    check_mem("restart");

    // Asynchronous reset between edges after 8 bytes
    @(negedge clk) load_start = 1'b1;
    @(negedge clk) load_start = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 8'hC0 + 8'(i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("pre_areset_cpu_hold", cpu_hold, 1);
    @(posedge clk);
    #2 n_reset = 1'b0;
    #1;
    chk("areset_cpu_hold", cpu_hold, 0);
    chk("areset_in_ready", in_ready, 0);
    chk("areset_load_done", load_done, 0);
    chk("areset_load_error", load_error, 0);
    for (int k = 0; k < 16; k++) exp_mem[k] = 8'h00;
    check_mem("areset");
    @(negedge clk) n_reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_areset_idle", cpu_hold, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
